forwarding_hazard_unit: RTL

Control block producing the 2-bit operand-select codes for the EX-stage forwarding multiplexers and the load-use stall/bubble request for the 5-stage RISC-V 32I pipeline. It keeps its own shadow pipeline of register-use metadata for the EX, MEM and WB stages, fed from the decoded ID-stage instruction, and advances it in lockstep with the datapath pipeline registers. It also keeps a saturating count of load-use stall cycles for performance debug.

---
 rtl/forwarding_hazard_unit_pkg.sv | 27 ++
 rtl/forwarding_hazard_unit_if.sv | 29 ++
 rtl/forwarding_hazard_unit_fwd_sel_gen.sv | 24 ++
 rtl/forwarding_hazard_unit.sv | 79 +++++++
 4 files changed

// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared constants and shadow-pipeline record types for the forwarding/hazard unit.
package fwd_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [REG_W-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } ex_rec_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
    } stage_rec_t;

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// ID-stage metadata in, operand selects / stall request / stall counter out.
interface forwarding_hazard_unit_if #(
    parameter int unsigned N_STALL_CNT = 32
);
    import fwd_pkg::*;

    logic                   id_valid;
    logic [REG_W-1:0]       id_rs1;
    logic [REG_W-1:0]       id_rs2;
    logic [REG_W-1:0]       id_rd;
    logic                   id_regwrite;
    logic                   id_memread;
    logic                   flush;
    logic [1:0]             fwd_a;
    logic [1:0]             fwd_b;
    logic                   stall;
    logic [N_STALL_CNT-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
        input  fwd_a, fwd_b, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
        output fwd_a, fwd_b, stall, stall_cnt
    );

endinterface

// File: rtl/forwarding_hazard_unit_fwd_sel_gen.sv
// Per-operand forwarding select; the younger EX/MEM producer beats MEM/WB, x0 never forwards.
module fwd_sel_gen
    import fwd_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_we,
    input  logic             mem_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_we,
    input  logic             wb_valid,
    output logic [1:0]       sel
);

    always_comb begin
        sel = FWD_NONE;
        if (mem_valid && mem_we && (mem_rd != REG_X0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_valid && wb_we && (wb_rd != REG_X0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Shadow EX/MEM/WB metadata pipeline driving operand-forward selects and the load-use stall.
module forwarding_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned N_STALL_CNT = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    forwarding_hazard_unit_if.slave   bus
);

    localparam logic [N_STALL_CNT-1:0] CNT_ONE = N_STALL_CNT'(1);

    ex_rec_t                ex_q;
    stage_rec_t             mem_q;
    stage_rec_t             wb_q;
    logic [N_STALL_CNT-1:0] cnt_q;
    logic                   stall;
    logic                   ex_bubble;

    // A flush kills the wrong-path ID instruction, so it also cancels any stall it would cause.
    always_comb begin
        stall = ex_q.valid && ex_q.memread && (ex_q.rd != REG_X0)
             && ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2))
             && bus.id_valid && !bus.flush;
        ex_bubble = stall || bus.flush || !bus.id_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
            if (ex_bubble) begin
                ex_q <= '0;
            end else begin
                ex_q <= '{valid:    1'b1,
                          rs1:      bus.id_rs1,
                          rs2:      bus.id_rs2,
                          rd:       bus.id_rd,
                          regwrite: bus.id_regwrite,
                          memread:  bus.id_memread};
            end
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    fwd_sel_gen u_sel_a (
        .rs        (ex_q.rs1),
        .mem_rd    (mem_q.rd),
        .mem_we    (mem_q.regwrite),
        .mem_valid (mem_q.valid),
        .wb_rd     (wb_q.rd),
        .wb_we     (wb_q.regwrite),
        .wb_valid  (wb_q.valid),
        .sel       (bus.fwd_a)
    );

    fwd_sel_gen u_sel_b (
        .rs        (ex_q.rs2),
        .mem_rd    (mem_q.rd),
        .mem_we    (mem_q.regwrite),
        .mem_valid (mem_q.valid),
        .wb_rd     (wb_q.rd),
        .wb_we     (wb_q.regwrite),
        .wb_valid  (wb_q.valid),
        .sel       (bus.fwd_b)
    );

    assign bus.stall     = stall;
    assign bus.stall_cnt = cnt_q;

endmodule
